// File: rtl/charmatrix_pkg.sv
// Shared geometry, address widths and sequencer state encoding for the
// serial character matrix (glyph store, config ROM, frame sequencer).
package charmatrix_pkg;

    localparam int CHAR_COLS     = 5;
    localparam int CHAR_ROWS     = 7;
    localparam int LEDS_PER_CHAR = 35;

    localparam int CHAR_W = 3;
    localparam int COL_W  = 3;
    localparam int ROW_W  = 3;
    localparam int LED_W  = 9;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(CHAR_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(CHAR_ROWS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_SEND,
        ST_LATCH
    } seq_state_e;

endpackage

// File: rtl/latch_gap_timer.sv
// Load/count-down timer: load sets CYCLES-1, counts to zero while enabled,
// expired_o is high while the count sits at zero.
module latch_gap_timer #(
    parameter int CYCLES = 2500
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(CYCLES - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/frame_sequencer.sv
// Walks every LED of the display in serpentine chain order, fetches its glyph
// bit and hands it to the WS2812 serializer, then holds the latch gap.
module frame_sequencer
    import charmatrix_pkg::*;
#(
    parameter int LATCH_CYCLES = 2500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CHAR_W-1:0] num_chars,
    input  logic [LED_W-1:0]  num_leds,
    output logic [CHAR_W-1:0] char_idx,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    input  logic              pixel_on,
    output logic              led_valid,
    output logic              led_on,
    input  logic              led_ready,
    output logic              busy,
    output logic              done
);

    seq_state_e        state_q, state_d;
    logic [CHAR_W-1:0] num_chars_q, num_chars_d;
    logic [LED_W-1:0]  num_leds_q, num_leds_d;
    logic [LED_W-1:0]  led_idx_q, led_idx_d;
    logic [CHAR_W-1:0] char_q, char_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              dir_up_q, dir_up_d;
    logic              led_on_q, led_on_d;
    logic              timer_load, timer_expired;
    logic              row_end, col_end, last_led;

    latch_gap_timer #(.CYCLES(LATCH_CYCLES)) u_latch_gap (
        .clk       (clk),
        .rst       (rst),
        .load_i    (timer_load),
        .en_i      (state_q == ST_LATCH),
        .expired_o (timer_expired)
    );

    assign row_end  = dir_up_q ? (row_q == '0) : (row_q == ROW_LAST);
    assign col_end  = (col_q == COL_LAST);
    // A config whose LED count overruns its character count stops at the last
    // character instead of addressing one that does not exist.
    assign last_led = (led_idx_q == num_leds_q) ||
                      (row_end && col_end && (char_q == num_chars_q));

    always_comb begin
        state_d     = state_q;
        num_chars_d = num_chars_q;
        num_leds_d  = num_leds_q;
        led_idx_d   = led_idx_q;
        char_d      = char_q;
        col_d       = col_q;
        row_d       = row_q;
        dir_up_d    = dir_up_q;
        led_on_d    = led_on_q;
        timer_load  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_chars_d = num_chars;
                    num_leds_d  = num_leds;
                    led_idx_d   = '0;
                    char_d      = '0;
                    col_d       = '0;
                    row_d       = '0;
                    dir_up_d    = 1'b0;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                led_on_d = pixel_on;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (led_ready) begin
                    if (last_led) begin
                        timer_load = 1'b1;
                        state_d    = ST_LATCH;
                    end else begin
                        led_idx_d = led_idx_q + 1'b1;
                        state_d   = ST_FETCH;
                        if (!row_end) begin
                            row_d = dir_up_q ? (row_q - 1'b1) : (row_q + 1'b1);
                        end else if (!col_end) begin
                            // Next column starts on the row we just finished.
                            col_d    = col_q + 1'b1;
                            dir_up_d = ~dir_up_q;
                        end else begin
                            char_d   = char_q + 1'b1;
                            col_d    = '0;
                            row_d    = '0;
                            dir_up_d = 1'b0;
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (timer_expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            num_chars_q <= '0;
            num_leds_q  <= '0;
            led_idx_q   <= '0;
            char_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            dir_up_q    <= 1'b0;
            led_on_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_chars_q <= num_chars_d;
            num_leds_q  <= num_leds_d;
            led_idx_q   <= led_idx_d;
            char_q      <= char_d;
            col_q       <= col_d;
            row_q       <= row_d;
            dir_up_q    <= dir_up_d;
            led_on_q    <= led_on_d;
        end
    end

    assign char_idx  = char_q;
    assign col       = col_q;
    assign row       = row_q;
    assign led_valid = (state_q == ST_SEND);
    assign led_on    = led_on_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_LATCH) && timer_expired;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench with an LED scoreboard filled from an index-division model
// and drained on every valid/ready transfer.
module tb_frame_sequencer;

    localparam int L = 20;

    logic       clk = 1'b0;
    logic       rst, start, pixel_on, led_ready;
    logic [2:0] num_chars, char_idx, col, row;
    logic [8:0] num_leds;
    logic       led_valid, led_on, busy, done;

    frame_sequencer #(.LATCH_CYCLES(L)) dut (
        .clk(clk), .rst(rst), .start(start), .num_chars(num_chars),
        .num_leds(num_leds), .char_idx(char_idx), .col(col), .row(row),
        .pixel_on(pixel_on), .led_valid(led_valid), .led_on(led_on),
        .led_ready(led_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Glyph store model: one-cycle synchronous read; pat 0 = all on, 1 = checkerboard.
    int pat = 0;
    always @(posedge clk)
        pixel_on <= (pat == 0) ? 1'b1 : 1'(int'(char_idx) + int'(col) + int'(row));

    typedef struct { int ch; int c; int r; int on; } led_t;
    led_t q[$];

    int   total = 0, bad = 0;
    int   xfers, ncyc = 0, last_x, done_cyc, done_cnt;
    bit   in_frame = 0, pv = 0, pr = 0;
    logic pon;
    logic [8:0] paddr;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called #1 after a posedge: a valid&&ready seen here transfers at the next edge.
    task automatic mon();
        led_t e;
        if (pv && !pr) begin
            chk("hold_valid", 32'(led_valid), 1);
            chk("hold_on", 32'(led_on), 32'(pon));
            chk("hold_addr", 32'({char_idx, col, row}), 32'(paddr));
        end
        if (in_frame) chk("busy", 32'(busy), 1);
        if (led_valid && led_ready) begin
            if (q.size() == 0) begin
                chk("queue_len", 32'(q.size()), 1);
            end else begin
                e = q.pop_front();
                chk("char", 32'(char_idx), e.ch);
                chk("col", 32'(col), e.c);
                chk("row", 32'(row), e.r);
                chk("led_on", 32'(led_on), e.on);
            end
            xfers++;
            last_x = ncyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = ncyc;
            in_frame = 0;
        end
        pv = led_valid; pr = led_ready; pon = led_on; paddr = {char_idx, col, row};
        ncyc++;
    endtask

    task automatic cyc();
        mon();
        @(posedge clk);
        #1;
    endtask

    function automatic int push_frame(int nc, int nl);
        int n, chn, rem, c, w, r;
        led_t e;
        n = (nl + 1 < (nc + 1) * 35) ? nl + 1 : (nc + 1) * 35;
        for (int i = 0; i < n; i++) begin
            chn = i / 35;
            rem = i % 35;
            c   = rem / 7;
            w   = rem % 7;
            r   = (c % 2 == 0) ? w : 6 - w;
            e.ch = chn; e.c = c; e.r = r;
            e.on = (pat == 0) ? 1 : (chn + c + r) % 2;
            q.push_back(e);
        end
        return n;
    endfunction

    task automatic run_frame(int nc, int nl, int stall_led, int mid_start, bit done_start);
        int n;
        bit stalled = 0;
        n = push_frame(nc, nl);
        xfers = 0; done_cnt = 0;
        num_chars = 3'(nc); num_leds = 9'(nl); start = 1;
        cyc();
        start = 0; in_frame = 1;
        num_chars = 3'd0; num_leds = 9'd0;
        chk("c1_valid", 32'(led_valid), 0);
        cyc();
        chk("c2_valid", 32'(led_valid), 0);
        cyc();
        chk("c3_valid", 32'(led_valid), 1);
        for (int k = 0; k < 3 * n + L + 60 && done_cnt == 0; k++) begin
            if (stall_led >= 0 && !stalled && xfers == stall_led && led_valid) begin
                led_ready = 0;
                repeat (10) cyc();
                led_ready = 1;
                stalled = 1;
            end
            start = (mid_start > 0 && xfers == mid_start) || (done_start && done);
            cyc();
        end
        start = 0;
        chk("done_seen", done_cnt, 1);
        chk("xfers", xfers, n);
        chk("latch_gap", done_cyc - last_x, L);
        chk("q_empty", 32'(q.size()), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        q.delete();
        in_frame = 0;
    endtask

    initial begin
        rst = 1; start = 0; led_ready = 1; num_chars = 3'd1; num_leds = 9'd69;
        cyc(); cyc();
        chk("rst_valid", 32'(led_valid), 0);
        chk("rst_on", 32'(led_on), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'({char_idx, col, row}), 0);
        rst = 0;
        cyc();

        pat = 0; run_frame(1, 69, -1, 0, 0);
        pat = 1; run_frame(1, 69, 3, 10, 1);
        cyc();
        chk("done_start_ignored", 32'(busy), 0);
        pat = 1; run_frame(7, 279, -1, 100, 0);
        pat = 0; run_frame(1, 279, -1, 0, 0);

        // Reset while LED 20 is being offered.
        pat = 0;
        void'(push_frame(1, 69));
        xfers = 0;
        num_chars = 3'd1; num_leds = 9'd69; start = 1;
        cyc();
        start = 0; in_frame = 1;
        for (int k = 0; k < 200 && !(xfers == 20 && led_valid); k++) cyc();
        chk("reached_led20", xfers, 20);
        led_ready = 0;
        cyc();
        rst = 1; in_frame = 0;
        cyc();
        rst = 0; pv = 0;
        chk("mrst_valid", 32'(led_valid), 0);
        chk("mrst_on", 32'(led_on), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_done", 32'(done), 0);
        chk("mrst_addr", 32'({char_idx, col, row}), 0);
        q.delete();
        led_ready = 1;
        cyc();
        pat = 1; run_frame(3, 139, -1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
